// File: rtl/sxp_dpram_pkg.sv
// Shared definitions for the SXP dual-port RAM.
//   state_e    : initialisation FSM encoding (INIT sweep, RUN)
//   RDW_OLD/NEW: cross-port read-during-write result selection
//   byte_merge : merges a new word into an old word under byte enables;
//                operates at MERGE_W bits so any DATA_WIDTH up to that fits
package sxp_dpram_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  localparam int MERGE_W  = 1024;
  localparam int MERGE_BE = MERGE_W / 8;

  function automatic logic [MERGE_W-1:0] byte_merge(
    input logic [MERGE_W-1:0]  old_w,
    input logic [MERGE_W-1:0]  new_w,
    input logic [MERGE_BE-1:0] be
  );
    logic [MERGE_W-1:0] merged;
    merged = old_w;
    for (int i = 0; i < MERGE_BE; i++) begin
      if (be[i]) merged[8*i +: 8] = new_w[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/sxp_dpram_rdport.sv
// Read-side pipeline for one RAM port.
//   rd_req   : a read was accepted at this edge
//   err_req  : the accepted request (read or write) was out of range
//   rd_data  : raw array word at the requested address
//   byp_sel  : take byp_data instead (cross-port write, new-data mode)
//   byp_data : merged word being written by the collision
//   q/valid/err : read data, one-cycle valid pulse, one-cycle range error
// OUT_REG=1 adds a second register stage in front of the outputs.
module sxp_dpram_rdport #(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_REG    = 0
) (
  input  logic                  clk,
  input  logic                  reset_b,
  input  logic                  rd_req,
  input  logic                  err_req,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  byp_sel,
  input  logic [DATA_WIDTH-1:0] byp_data,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  valid,
  output logic                  err
);

  logic                  valid_s1;
  logic                  err_s1;
  logic [DATA_WIDTH-1:0] data_s1;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its sources, independent of block order.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      valid_s1 <= 1'b0;
      err_s1   <= 1'b0;
      data_s1  <= '0;
    end else begin
      valid_s1 <= rd_req;
      err_s1   <= err_req;
      // Data only moves on a read, so q holds between reads.
      if (rd_req) data_s1 <= err_req ? '0 : (byp_sel ? byp_data : rd_data);
    end
  end

  if (OUT_REG == 0) begin : g_direct
    assign q     = data_s1;
    assign valid = valid_s1;
    assign err   = err_s1;
  end else begin : g_outreg
    logic                  valid_s2;
    logic                  err_s2;
    logic [DATA_WIDTH-1:0] data_s2;

    always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
        valid_s2 <= 1'b0;
        err_s2   <= 1'b0;
        data_s2  <= '0;
      end else begin
        valid_s2 <= valid_s1;
        err_s2   <= err_s1;
        if (valid_s1) data_s2 <= data_s1;
      end
    end

    assign q     = data_s2;
    assign valid = valid_s2;
    assign err   = err_s2;
  end

endmodule

// File: rtl/sxp_dpram.sv
// Parametrised dual-port synchronous RAM for the SXP processor.
//   clk, reset_b            : clock, asynchronous active-low reset
//   en*/we*/be*/addr*/d*    : per-port request, write select, byte enables,
//                             word address, write data
//   q*/valid_*/err_*        : per-port read data, read-valid pulse,
//                             out-of-range pulse
//   coll                    : same-address cross-port access with a write
//   init_done               : init sweep finished, requests accepted
// After reset the array is swept to INIT_VALUE one word per clock; requests
// are ignored until the sweep completes.
import sxp_dpram_pkg::*;

module sxp_dpram #(
  parameter int                      DATA_WIDTH = 32,
  parameter int                      ADDR_WIDTH = 10,
  parameter int                      DEPTH      = 1024,
  parameter int                      OUT_REG    = 0,
  parameter int                      RDW_MODE   = 0,
  parameter logic [DATA_WIDTH-1:0]   INIT_VALUE = '0
) (
  input  logic                    clk,
  input  logic                    reset_b,
  input  logic                    ena,
  input  logic                    wea,
  input  logic [DATA_WIDTH/8-1:0] bea,
  input  logic [ADDR_WIDTH-1:0]   addra,
  input  logic [DATA_WIDTH-1:0]   da,
  output logic [DATA_WIDTH-1:0]   qa,
  output logic                    valid_a,
  output logic                    err_a,
  input  logic                    enb,
  input  logic                    web,
  input  logic [DATA_WIDTH/8-1:0] beb,
  input  logic [ADDR_WIDTH-1:0]   addrb,
  input  logic [DATA_WIDTH-1:0]   db,
  output logic [DATA_WIDTH-1:0]   qb,
  output logic                    valid_b,
  output logic                    err_b,
  output logic                    coll,
  output logic                    init_done
);

  localparam int BW = DATA_WIDTH / 8;

  function automatic logic [DATA_WIDTH-1:0] merge(
    input logic [DATA_WIDTH-1:0] old_w,
    input logic [DATA_WIDTH-1:0] new_w,
    input logic [BW-1:0]         be
  );
    return DATA_WIDTH'(byte_merge(MERGE_W'(old_w), MERGE_W'(new_w), MERGE_BE'(be)));
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // ---------------- init FSM ----------------
  state_e                state, state_nxt;
  logic [ADDR_WIDTH-1:0] init_cnt;
  logic                  init_last;
  logic                  init_we;
  logic                  run;

  assign init_last = (init_cnt == ADDR_WIDTH'(DEPTH - 1));

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state    <= ST_INIT;
      init_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (init_we && !init_last) init_cnt <= init_cnt + 1'b1;
    end
  end

  always_comb begin
    // NOTE: default assignment first so no path leaves the signal unassigned
    // (otherwise a latch is inferred).
    state_nxt = state;
    case (state)
      ST_INIT: if (init_last) state_nxt = ST_RUN;
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = ST_INIT;
    endcase
  end

  always_comb begin
    init_we = (state == ST_INIT);
    run     = (state == ST_RUN);
  end

  assign init_done = run;

  // ---------------- request decode ----------------
  logic oor_a, oor_b;
  logic wr_a, wr_b, rd_a, rd_b;
  logic same;
  logic [BW-1:0] be_a_eff, be_b_eff;
  logic [DATA_WIDTH-1:0] word_a, word_b, wnew_a, wnew_b;

  // Range check at full width; the extra bit keeps DEPTH == 2**ADDR_WIDTH legal.
  assign oor_a = ({1'b0, addra} >= (ADDR_WIDTH+1)'(DEPTH));
  assign oor_b = ({1'b0, addrb} >= (ADDR_WIDTH+1)'(DEPTH));

  assign wr_a = run & ena & wea & ~oor_a;
  assign wr_b = run & enb & web & ~oor_b;
  assign rd_a = run & ena & ~wea;
  assign rd_b = run & enb & ~web;

  assign same = run & ena & enb & (addra == addrb) & ~oor_a & (wea | web);

  assign be_a_eff = wr_a ? bea : '0;
  assign be_b_eff = wr_b ? beb : '0;

  assign word_a = mem[addra];
  assign word_b = mem[addrb];

  // On a shared address wnew_a carries both ports' bytes, A applied last so
  // it wins per byte; it is also the new word a colliding reader sees.
  assign wnew_a = merge(merge(word_a, db, same ? be_b_eff : '0), da, be_a_eff);
  assign wnew_b = merge(word_b, db, be_b_eff);

  // NOTE: the array has no reset; it is brought to a known value by the
  // init sweep, which keeps it mappable onto RAM macros.
  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[init_cnt] <= INIT_VALUE;
    end else begin
      if (wr_a)                  mem[addra] <= wnew_a;
      if (wr_b && !(same && wr_a)) mem[addrb] <= wnew_b;
    end
  end

  // ---------------- read ports ----------------
  localparam logic NEW_MODE = (RDW_MODE == RDW_NEW);

  sxp_dpram_rdport #(.DATA_WIDTH(DATA_WIDTH), .OUT_REG(OUT_REG)) u_rdport_a (
    .clk      (clk),
    .reset_b  (reset_b),
    .rd_req   (rd_a),
    .err_req  (run & ena & oor_a),
    .rd_data  (word_a),
    .byp_sel  (same & NEW_MODE),
    .byp_data (wnew_a),
    .q        (qa),
    .valid    (valid_a),
    .err      (err_a)
  );

  sxp_dpram_rdport #(.DATA_WIDTH(DATA_WIDTH), .OUT_REG(OUT_REG)) u_rdport_b (
    .clk      (clk),
    .reset_b  (reset_b),
    .rd_req   (rd_b),
    .err_req  (run & enb & oor_b),
    .rd_data  (word_b),
    .byp_sel  (same & NEW_MODE),
    .byp_data (wnew_a),
    .q        (qb),
    .valid    (valid_b),
    .err      (err_b)
  );

  // ---------------- collision flag ----------------
  logic coll_s1;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) coll_s1 <= 1'b0;
    else          coll_s1 <= same;
  end

  if (OUT_REG == 0) begin : g_coll_direct
    assign coll = coll_s1;
  end else begin : g_coll_reg
    logic coll_s2;
    always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) coll_s2 <= 1'b0;
      else          coll_s2 <= coll_s1;
    end
    assign coll = coll_s2;
  end

`ifndef SYNTHESIS
  task automatic mem_dump(input int start, input int count);
    for (int i = start; (i < start + count) && (i < DEPTH); i++) begin
      $display("mem[%0d] = %h", i, mem[i]);
    end
  endtask
`endif

endmodule

// File: tb/tb_sxp_dpram.sv
// Scoreboard bench for sxp_dpram. Two instances share one stimulus stream:
// dut 0 = OUT_REG 0 / old-data mode, dut 1 = OUT_REG 1 / new-data mode.
`timescale 1ns/1ps
module tb_sxp_dpram;

  localparam int DW = 32, AW = 10, DEPTH = 1000, BW = 4;

  logic clk = 1'b0;
  logic reset_b = 1'b0;
  always #5 clk = ~clk;

  logic          ena, wea, enb, web;
  logic [BW-1:0] bea, beb;
  logic [AW-1:0] addra, addrb;
  logic [DW-1:0] da, db;

  // port index: 0 = dut0 A, 1 = dut0 B, 2 = dut1 A, 3 = dut1 B
  logic [DW-1:0] q_o [4];
  logic          v_o [4];
  logic          e_o [4];
  logic          coll_o [2];
  logic          idone_o [2];

  sxp_dpram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
              .OUT_REG(0), .RDW_MODE(0), .INIT_VALUE('0)) u_dut0 (
    .clk(clk), .reset_b(reset_b),
    .ena(ena), .wea(wea), .bea(bea), .addra(addra), .da(da),
    .qa(q_o[0]), .valid_a(v_o[0]), .err_a(e_o[0]),
    .enb(enb), .web(web), .beb(beb), .addrb(addrb), .db(db),
    .qb(q_o[1]), .valid_b(v_o[1]), .err_b(e_o[1]),
    .coll(coll_o[0]), .init_done(idone_o[0])
  );

  sxp_dpram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
              .OUT_REG(1), .RDW_MODE(1), .INIT_VALUE('0)) u_dut1 (
    .clk(clk), .reset_b(reset_b),
    .ena(ena), .wea(wea), .bea(bea), .addra(addra), .da(da),
    .qa(q_o[2]), .valid_a(v_o[2]), .err_a(e_o[2]),
    .enb(enb), .web(web), .beb(beb), .addrb(addrb), .db(db),
    .qb(q_o[3]), .valid_b(v_o[3]), .err_b(e_o[3]),
    .coll(coll_o[1]), .init_done(idone_o[1])
  );

  typedef struct {
    int        due;
    bit        v;
    bit        e;
    logic [DW-1:0] d;
  } exp_t;

  exp_t          sb [4][$];
  int            coll_sb [2][$];
  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] last_q [4];
  int            cyc = 0;
  int            since_rst = 0;
  bit            run_m = 1'b0;
  int            vectors = 0;
  int            miscompares = 0;

  task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp_v, cyc);
    end
  endtask

  function automatic logic [DW-1:0] bmerge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                           input logic [BW-1:0] be);
    logic [DW-1:0] r;
    r = o;
    for (int i = 0; i < BW; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  task automatic mon();
    for (int p = 0; p < 4; p++) begin
      bit ev, ee;
      ev = 1'b0;
      ee = 1'b0;
      if (sb[p].size() > 0 && sb[p][0].due == cyc) begin
        ev = sb[p][0].v;
        ee = sb[p][0].e;
        if (ev) last_q[p] = sb[p][0].d;
        void'(sb[p].pop_front());
      end
      check($sformatf("valid[%0d]", p), DW'(v_o[p]), DW'(ev));
      check($sformatf("err[%0d]", p),   DW'(e_o[p]), DW'(ee));
      check($sformatf("q[%0d]", p),     q_o[p],      last_q[p]);
    end
    for (int d = 0; d < 2; d++) begin
      bit ec;
      ec = 1'b0;
      if (coll_sb[d].size() > 0 && coll_sb[d][0] == cyc) begin
        ec = 1'b1;
        void'(coll_sb[d].pop_front());
      end
      check($sformatf("coll[%0d]", d),      DW'(coll_o[d]),  DW'(ec));
      check($sformatf("init_done[%0d]", d), DW'(idone_o[d]), DW'(run_m));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (!run_m) begin
      since_rst++;
      if (since_rst == DEPTH) run_m = 1'b1;
    end
    mon();
  endtask

  task automatic issue(input bit ea, input bit wa, input logic [BW-1:0] bea_i,
                       input logic [AW-1:0] aa, input logic [DW-1:0] da_i,
                       input bit eb, input bit wb, input logic [BW-1:0] beb_i,
                       input logic [AW-1:0] ab, input logic [DW-1:0] db_i);
    bit oa, ob, cc;
    logic [DW-1:0] old_a, old_b, new_a, new_b;
    ena = ea; wea = wa; bea = bea_i; addra = aa; da = da_i;
    enb = eb; web = wb; beb = beb_i; addrb = ab; db = db_i;
    if (run_m) begin
      oa = (int'(aa) >= DEPTH);
      ob = (int'(ab) >= DEPTH);
      old_a = oa ? '0 : model[aa];
      old_b = ob ? '0 : model[ab];
      cc = ea && eb && (aa == ab) && !oa && (wa || wb);
      if (eb && wb && !ob) model[ab] = bmerge(model[ab], db_i, beb_i);
      if (ea && wa && !oa) model[aa] = bmerge(model[aa], da_i, bea_i);
      new_a = oa ? '0 : model[aa];
      new_b = ob ? '0 : model[ab];
      if (ea && (!wa || oa)) begin
        sb[0].push_back('{cyc + 1, !wa, oa, old_a});
        sb[2].push_back('{cyc + 2, !wa, oa, cc ? new_a : old_a});
      end
      if (eb && (!wb || ob)) begin
        sb[1].push_back('{cyc + 1, !wb, ob, old_b});
        sb[3].push_back('{cyc + 2, !wb, ob, cc ? new_b : old_b});
      end
      if (cc) begin
        coll_sb[0].push_back(cyc + 1);
        coll_sb[1].push_back(cyc + 2);
      end
    end
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) issue(0, 0, '0, '0, '0, 0, 0, '0, '0, '0);
  endtask

  task automatic rd_a(input logic [AW-1:0] a);
    issue(1, 0, '0, a, '0, 0, 0, '0, '0, '0);
  endtask

  task automatic rd_b(input logic [AW-1:0] a);
    issue(0, 0, '0, '0, '0, 1, 0, '0, a, '0);
  endtask

  task automatic wr_a(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be);
    issue(1, 1, be, a, d, 0, 0, '0, '0, '0);
  endtask

  task automatic wr_b(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be);
    issue(0, 0, '0, '0, '0, 1, 1, be, a, d);
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    for (int p = 0; p < 4; p++) begin
      sb[p].delete();
      last_q[p] = '0;
    end
    coll_sb[0].delete();
    coll_sb[1].delete();
    run_m = 1'b0;
    since_rst = 0;
  endtask

  task automatic init_sweep();
    // Port A keeps writing addr 5 throughout; none of it may land.
    for (int i = 0; i < DEPTH + 4 && !run_m; i++)
      issue(1, 1, 4'hF, AW'(5), 32'hFFFF_FFFF, 0, 0, '0, '0, '0);
    check("init_done_reached", DW'(run_m), DW'(1'b1));
  endtask

  initial begin
    ena = 0; wea = 0; bea = '0; addra = '0; da = '0;
    enb = 0; web = 0; beb = '0; addrb = '0; db = '0;
    clear_model();

    #2;
    mon();                                   // outputs under reset
    @(negedge clk);
    reset_b = 1'b1;
    init_sweep();
    rd_a(AW'(5));
    idle(3);

    // Byte write: expect AA22CC44
    wr_a(AW'(3), 32'hAABB_CCDD, 4'b1111);
    wr_a(AW'(3), 32'h1122_3344, 4'b0101);
    rd_a(AW'(3));
    idle(3);
    check("model_byte_write", model[3], 32'hAA22_CC44);
    wr_b(AW'(4), 32'h1234_5678, 4'b0000);    // be=0 is a no-op
    rd_b(AW'(4));
    idle(3);

    // Dual write collision on addr 7: expect 22221111
    issue(1, 1, 4'b0011, AW'(7), 32'h1111_1111, 1, 1, 4'b1111, AW'(7), 32'h2222_2222);
    rd_a(AW'(7));
    idle(3);
    check("model_dual_write", model[7], 32'h2222_1111);

    // A writes / B reads addr 9 (old value 5)
    wr_a(AW'(9), 32'h5, 4'hF);
    issue(1, 1, 4'hF, AW'(9), 32'hF, 1, 0, '0, AW'(9), '0);
    issue(1, 0, '0, AW'(9), '0, 1, 0, '0, AW'(9), '0);   // both read: no coll
    issue(1, 0, '0, AW'(9), '0, 1, 1, 4'b0001, AW'(9), 32'hAB); // B writes / A reads
    idle(3);

    // Out of range
    wr_a(AW'(999), 32'h0000_1234, 4'hF);
    wr_b(AW'(1000), 32'h0000_DEAD, 4'hF);
    rd_b(AW'(1000));
    rd_b(AW'(999));
    rd_a(AW'(1023));
    issue(1, 1, 4'hF, AW'(1001), 32'h1, 1, 1, 4'hF, AW'(1001), 32'h2); // no coll out of range
    idle(3);

    // Random traffic over a small window plus out-of-range addresses
    for (int i = 0; i < 300; i++) begin
      int ra, rb;
      ra = $urandom_range(0, 19);
      rb = $urandom_range(0, 19);
      issue(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), BW'($urandom_range(0, 15)),
            AW'(ra < 16 ? ra : 982 + ra), $urandom,
            bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), BW'($urandom_range(0, 15)),
            AW'(rb < 16 ? rb : 982 + rb), $urandom);
    end
    idle(3);

    // Reset with a collision pending in dut1's output register
    wr_a(AW'(3), 32'hCAFE_F00D, 4'hF);
    issue(1, 1, 4'hF, AW'(3), 32'h0BAD_BEEF, 1, 0, '0, AW'(3), '0);
    #1;
    reset_b = 1'b0;
    #1;
    for (int p = 0; p < 4; p++) begin
      check($sformatf("rst_q[%0d]", p),     q_o[p],      '0);
      check($sformatf("rst_valid[%0d]", p), DW'(v_o[p]), '0);
      check($sformatf("rst_err[%0d]", p),   DW'(e_o[p]), '0);
    end
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_coll[%0d]", d),  DW'(coll_o[d]),  '0);
      check($sformatf("rst_idone[%0d]", d), DW'(idone_o[d]), '0);
    end
    clear_model();
    @(negedge clk);
    @(negedge clk);
    reset_b = 1'b1;
    init_sweep();
    rd_a(AW'(3));
    rd_b(AW'(0));
    rd_b(AW'(DEPTH - 1));
    idle(3);

    for (int p = 0; p < 4; p++) check($sformatf("sb_drained[%0d]", p), DW'(sb[p].size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
